mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide memory port between an I-cache, a
// D-cache and a DMA master. Cache transactions run IDLE->CMD->WAIT->DONE
// and are never preempted; the DMA master owns the port for as long as it
// holds dma_br once granted. A fairness flag set on DMA exit lets the
// caches go first at the next arbitration.
//
// Handshake semantics: a cache raises *_req and holds it (with a stable
// address) until its one-cycle *_done pulse, then drops it for at least the
// following cycle; *_rdata is valid while *_done is high. The DMA master
// raises dma_br and keeps it high for its whole tenure; its dma_read /
// dma_write / dma_addr / dma_wdata reach the memory port only while
// dma_bg is high, and dropping dma_br ends the tenure on the next cycle.
module mem_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int FETCH_SIZE  = 64,
  parameter int MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [WORD_SIZE-1:0]  i_addr,
  output logic [FETCH_SIZE-1:0] i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [WORD_SIZE-1:0]  d_addr,
  input  logic [FETCH_SIZE-1:0] d_wdata,
  output logic [FETCH_SIZE-1:0] d_rdata,
  output logic                  d_done,
  input  logic                  dma_br,
  output logic                  dma_bg,
  input  logic                  dma_read,
  input  logic                  dma_write,
  input  logic [WORD_SIZE-1:0]  dma_addr,
  input  logic [FETCH_SIZE-1:0] dma_wdata,
  output logic                  m_read,
  output logic                  m_write,
  output logic [WORD_SIZE-1:0]  m_addr,
  output logic [FETCH_SIZE-1:0] m_wdata,
  input  logic [FETCH_SIZE-1:0] m_rdata,
  output logic [WORD_SIZE-1:0]  i_grant_cnt,
  output logic [WORD_SIZE-1:0]  d_grant_cnt,
  output logic [WORD_SIZE-1:0]  dma_grant_cnt,
  output logic [2:0]            dbg_state_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_DMA  = 3'd4;

  // WAIT counts down from this value to zero, so it spans MEM_LATENCY
  // cycles and the last WAIT cycle is the one where m_rdata is valid.
  localparam logic [3:0]           WAIT_LOAD  = 4'(MEM_LATENCY - 1);
  localparam logic [WORD_SIZE-1:0] BLOCK_MASK = ~WORD_SIZE'(3);
  localparam logic [WORD_SIZE-1:0] CNT_ONE    = WORD_SIZE'(1);

  logic [2:0]            state_q, state_d;
  logic                  fair_q, fair_d;
  logic                  own_d_q, own_d_d;   // 1: D-cache owns the port, 0: I-cache
  logic                  we_q, we_d;
  logic [WORD_SIZE-1:0]  addr_q, addr_d;
  logic [FETCH_SIZE-1:0] wdata_q, wdata_d;
  logic [3:0]            wait_q, wait_d;
  logic [FETCH_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [FETCH_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic [WORD_SIZE-1:0]  i_cnt_q, i_cnt_d;
  logic [WORD_SIZE-1:0]  d_cnt_q, d_cnt_d;
  logic [WORD_SIZE-1:0]  dma_cnt_q, dma_cnt_d;
  logic                  grant_i, grant_d, grant_dma;
  logic                  in_cmd, in_wait, in_dma;

  // Arbitration in IDLE: DMA first normally, caches first after a DMA tenure.
  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    grant_dma = 1'b0;
    if (state_q == S_IDLE) begin
      if (fair_q) begin
        grant_d   = d_req;
        grant_i   = !d_req && i_req;
        grant_dma = !d_req && !i_req && dma_br;
      end else begin
        grant_dma = dma_br;
        grant_d   = !dma_br && d_req;
        grant_i   = !dma_br && !d_req && i_req;
      end
    end
  end

  // Next-state logic: transaction sequencing, latching, capture and counters.
  always_comb begin
    state_d   = state_q;
    fair_d    = fair_q;
    own_d_d   = own_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wait_d    = wait_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_cnt_d   = i_cnt_q;
    d_cnt_d   = d_cnt_q;
    dma_cnt_d = dma_cnt_q;
    case (state_q)
      S_IDLE: begin
        // Any IDLE cycle either grants a cache or sees no cache request,
        // so the fairness flag never survives an IDLE cycle.
        fair_d = 1'b0;
        if (grant_dma) begin
          state_d   = S_DMA;
          dma_cnt_d = dma_cnt_q + CNT_ONE;
        end else if (grant_d || grant_i) begin
          state_d = S_CMD;
          own_d_d = grant_d;
          we_d    = grant_d && d_we;
          addr_d  = (grant_d ? d_addr : i_addr) & BLOCK_MASK;
          wdata_d = grant_d ? d_wdata : '0;
          if (grant_d) d_cnt_d = d_cnt_q + CNT_ONE;
          else         i_cnt_d = i_cnt_q + CNT_ONE;
        end
      end
      S_CMD: begin
        wait_d  = WAIT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (own_d_q) d_rdata_d = m_rdata;
            else         i_rdata_d = m_rdata;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DMA: begin
        if (!dma_br) begin
          state_d = S_IDLE;
          fair_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      fair_q    <= 1'b0;
      own_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_q    <= 4'd0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_cnt_q   <= '0;
      d_cnt_q   <= '0;
      dma_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fair_q    <= fair_d;
      own_d_q   <= own_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wait_q    <= wait_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
      dma_cnt_q <= dma_cnt_d;
    end
  end

  assign in_cmd  = (state_q == S_CMD);
  assign in_wait = (state_q == S_WAIT);
  assign in_dma  = (state_q == S_DMA);

  // Memory port mux: latched cache command in CMD/WAIT, DMA pass-through in DMA.
  always_comb begin
    m_read  = 1'b0;
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (in_cmd) begin
      m_read  = !we_q;
      m_write = we_q;
      m_addr  = addr_q;
      m_wdata = wdata_q;
    end else if (in_wait) begin
      m_addr = addr_q;
    end else if (in_dma) begin
      m_read  = dma_read;
      m_write = dma_write;
      m_addr  = dma_addr;
      m_wdata = dma_wdata;
    end
  end

  assign i_done        = (state_q == S_DONE) && !own_d_q;
  assign d_done        = (state_q == S_DONE) && own_d_q;
  assign dma_bg        = in_dma;
  assign i_rdata       = i_rdata_q;
  assign d_rdata       = d_rdata_q;
  assign i_grant_cnt   = i_cnt_q;
  assign d_grant_cnt   = d_cnt_q;
  assign dma_grant_cnt = dma_cnt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model,
// then a counter-wrap run on a narrow second instance.
module tb_mem_arbiter;
  localparam int WS  = 16;
  localparam int FS  = 64;
  localparam int ML  = 4;
  localparam int WS2 = 8;
  localparam int FS2 = 32;
  localparam int ML2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic i_req, d_req, d_we, dma_br, dma_read, dma_write;
  logic [WS-1:0] i_addr, d_addr, dma_addr;
  logic [FS-1:0] d_wdata, dma_wdata, m_rdata;
  logic [FS-1:0] i_rdata, d_rdata, m_wdata;
  logic i_done, d_done, dma_bg, m_read, m_write;
  logic [WS-1:0] m_addr, i_grant_cnt, d_grant_cnt, dma_grant_cnt;
  logic [2:0] dbg_state;

  mem_arbiter #(.WORD_SIZE(WS), .FETCH_SIZE(FS), .MEM_LATENCY(ML)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .dma_br(dma_br), .dma_bg(dma_bg), .dma_read(dma_read), .dma_write(dma_write),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .dma_grant_cnt(dma_grant_cnt),
    .dbg_state_o(dbg_state)
  );

  // Narrow instance used for the grant-counter wrap and minimum latency.
  logic w_reset, w_i_req, w_d_req, w_d_we, w_dma_br, w_dma_read, w_dma_write;
  logic [WS2-1:0] w_i_addr, w_d_addr, w_dma_addr;
  logic [FS2-1:0] w_d_wdata, w_dma_wdata, w_m_rdata;
  logic [FS2-1:0] w_i_rdata, w_d_rdata, w_m_wdata;
  logic w_i_done, w_d_done, w_dma_bg, w_m_read, w_m_write;
  logic [WS2-1:0] w_m_addr, w_i_cnt, w_d_cnt, w_dma_cnt;
  logic [2:0] w_dbg_state;

  mem_arbiter #(.WORD_SIZE(WS2), .FETCH_SIZE(FS2), .MEM_LATENCY(ML2)) dut_w (
    .clk(clk), .reset(w_reset),
    .i_req(w_i_req), .i_addr(w_i_addr), .i_rdata(w_i_rdata), .i_done(w_i_done),
    .d_req(w_d_req), .d_we(w_d_we), .d_addr(w_d_addr), .d_wdata(w_d_wdata),
    .d_rdata(w_d_rdata), .d_done(w_d_done),
    .dma_br(w_dma_br), .dma_bg(w_dma_bg), .dma_read(w_dma_read), .dma_write(w_dma_write),
    .dma_addr(w_dma_addr), .dma_wdata(w_dma_wdata),
    .m_read(w_m_read), .m_write(w_m_write), .m_addr(w_m_addr), .m_wdata(w_m_wdata),
    .m_rdata(w_m_rdata),
    .i_grant_cnt(w_i_cnt), .d_grant_cnt(w_d_cnt), .dma_grant_cnt(w_dma_cnt),
    .dbg_state_o(w_dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner: 0 none, 1 I-cache, 2 D-cache, 3 DMA. ph = cycles since the grant.
  int            mo = 0;
  int            ph = 0;
  logic          mfair = 1'b0;
  logic          mwe = 1'b0;
  logic [WS-1:0] maddr = '0;
  logic [FS-1:0] mwd = '0;
  logic [FS-1:0] mi_rd = '0, md_rd = '0;
  logic [WS-1:0] mic = '0, mdc = '0, mdmac = '0;

  initial begin
    int winner;
    forever begin
      @(posedge clk);
      if (reset) begin
        mo = 0; ph = 0; mfair = 1'b0; mwe = 1'b0; maddr = '0; mwd = '0;
        mi_rd = '0; md_rd = '0; mic = '0; mdc = '0; mdmac = '0;
      end else if (mo == 0) begin
        if (mfair) winner = d_req ? 2 : (i_req ? 1 : (dma_br ? 3 : 0));
        else       winner = dma_br ? 3 : (d_req ? 2 : (i_req ? 1 : 0));
        mfair = 1'b0;
        if (winner == 3) begin
          mo = 3; mdmac = mdmac + 1'b1;
        end else if (winner != 0) begin
          mo    = winner;
          ph    = 1;
          mwe   = (winner == 2) && d_we;
          maddr = ((winner == 2) ? d_addr : i_addr) & 16'hFFFC;
          mwd   = (winner == 2) ? d_wdata : '0;
          if (winner == 2) mdc = mdc + 1'b1;
          else             mic = mic + 1'b1;
        end
      end else if (mo == 3) begin
        if (!dma_br) begin mo = 0; mfair = 1'b1; end
      end else begin
        if (ph == ML + 1 && !mwe) begin
          if (mo == 2) md_rd = m_rdata;
          else         mi_rd = m_rdata;
        end
        if (ph == ML + 2) mo = 0;
        else              ph = ph + 1;
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic cmd, wt, dn;
    if (chk_en) begin
      cmd = (mo == 1 || mo == 2) && ph == 1;
      wt  = (mo == 1 || mo == 2) && ph >= 2 && ph <= ML + 1;
      dn  = (mo == 1 || mo == 2) && ph == ML + 2;
      chk("m_read",  m_read,  cmd ? !mwe : (mo == 3 ? dma_read : 1'b0));
      chk("m_write", m_write, cmd ? mwe : (mo == 3 ? dma_write : 1'b0));
      chk("m_addr",  m_addr,  (cmd || wt) ? maddr : (mo == 3 ? dma_addr : '0));
      chk("m_wdata", m_wdata, cmd ? mwd : (mo == 3 ? dma_wdata : '0));
      chk("i_done",  i_done,  dn && mo == 1);
      chk("d_done",  d_done,  dn && mo == 2);
      chk("dma_bg",  dma_bg,  mo == 3);
      chk("i_rdata", i_rdata, mi_rd);
      chk("d_rdata", d_rdata, md_rd);
      chk("i_cnt",   i_grant_cnt, mic);
      chk("d_cnt",   d_grant_cnt, mdc);
      chk("dma_cnt", dma_grant_cnt, mdmac);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int n);
    logic pi, pd, pbg;
    int tenure, bgcnt;
    tenure = 1;
    bgcnt  = 0;
    for (int c = 0; c < n; c++) begin
      pi = i_done; pd = d_done; pbg = dma_bg;
      step();
      m_rdata = {$urandom, $urandom};
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) reset = 1'b1;
      if (pi) i_req = 1'b0;
      else if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req = 1'b1; i_addr = WS'($urandom);
      end
      if (pd) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = WS'($urandom);
        d_wdata = {$urandom, $urandom};
      end
      if (!dma_br) begin
        if ($urandom_range(0, 7) == 0) begin
          dma_br = 1'b1; tenure = $urandom_range(1, 5); bgcnt = 0;
        end
      end else begin
        if (pbg) bgcnt++;
        if (bgcnt >= tenure) dma_br = 1'b0;
      end
      dma_read  = 1'($urandom);
      dma_write = 1'($urandom);
      dma_addr  = WS'($urandom);
      dma_wdata = {$urandom, $urandom};
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; dma_br = 0; dma_read = 0; dma_write = 0;
    i_addr = '0; d_addr = '0; dma_addr = '0; d_wdata = '0; dma_wdata = '0; m_rdata = '0;
    w_reset = 1'b1; w_i_req = 0; w_d_req = 0; w_d_we = 0; w_dma_br = 0; w_dma_read = 0;
    w_dma_write = 0; w_i_addr = '0; w_d_addr = '0; w_dma_addr = '0; w_d_wdata = '0;
    w_dma_wdata = '0; w_m_rdata = 32'h1357_9BDF;
    step();
    reset  = 1'b0;
    chk_en = 1'b1;
    // Reset state (cycle 0)
    chk("rst_i_done", i_done, 0); chk("rst_dma_bg", dma_bg, 0);
    chk("rst_m_read", m_read, 0); chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_cnt", d_grant_cnt, 0);

    // I-cache fill, single requester
    i_req = 1; i_addr = 16'h0123;
    step();
    chk("r39_m_read", m_read, 1); chk("r39_m_addr", m_addr, 16'h0120);
    repeat (4) step();
    m_rdata = 64'hA5A5_0000_1111_2222;
    step();
    chk("r39_i_done", i_done, 1); chk("r39_i_rdata", i_rdata, 64'hA5A5_0000_1111_2222);
    m_rdata = '0;
    step();
    i_req = 0;
    chk("r39_done_pulse", i_done, 0);
    step();

    // I and D together: D writeback first, then I fill
    i_req = 1; i_addr = 16'h0357;
    d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 64'hDEAD_BEEF_0123_4567;
    step();
    chk("r40_m_write", m_write, 1); chk("r40_m_read", m_read, 0);
    chk("r40_m_addr", m_addr, 16'h0040); chk("r40_m_wdata", m_wdata, 64'hDEAD_BEEF_0123_4567);
    repeat (5) step();
    chk("r40_d_done", d_done, 1); chk("r40_d_rdata", d_rdata, 0);
    step();
    d_req = 0; d_we = 0;
    step();
    chk("r40_i_m_read", m_read, 1); chk("r40_i_m_addr", m_addr, 16'h0354);
    repeat (5) step();
    chk("r40_i_done", i_done, 1);
    step();
    i_req = 0;
    step();
    chk("r40_i_cnt", i_grant_cnt, 2); chk("r40_d_cnt", d_grant_cnt, 1);

    // D fill with DMA request arriving mid-transaction, then fairness
    d_req = 1; d_we = 0; d_addr = 16'h1238;
    step(); step();
    dma_br = 1;
    repeat (4) step();
    chk("r41_d_done", d_done, 1); chk("r41_bg_wait", dma_bg, 0);
    step();
    d_req = 0;
    step();
    chk("r41_dma_bg", dma_bg, 1);
    dma_read = 1; dma_addr = 16'hBEEF; dma_wdata = 64'h0F0F_0F0F_0F0F_0F0F;
    #1;
    chk("r41_pass_read", m_read, 1); chk("r41_pass_addr", m_addr, 16'hBEEF);
    chk("r41_pass_write", m_write, 0);
    dma_read = 0;
    step();
    dma_br = 0; d_req = 1; d_we = 1; d_addr = 16'h2222; d_wdata = 64'h1111_2222_3333_4444;
    step();
    chk("r42_bg_off", dma_bg, 0);
    dma_br = 1;
    step();
    chk("r42_d_first", m_write, 1); chk("r42_addr", m_addr, 16'h2220);
    chk("r42_no_bg", dma_bg, 0);
    repeat (5) step();
    chk("r42_d_done", d_done, 1);
    step();
    d_req = 0; d_we = 0;
    step();
    chk("r42_dma_after", dma_bg, 1); chk("r42_dma_cnt", dma_grant_cnt, 2);
    dma_br = 0;
    step(); step();

    // Reset during WAIT
    i_req = 1; i_addr = 16'h0400;
    repeat (3) step();
    reset = 1;
    step();
    reset = 0; i_req = 0;
    chk("r43_m_read", m_read, 0); chk("r43_m_addr", m_addr, 0);
    chk("r43_bg", dma_bg, 0); chk("r43_i_cnt", i_grant_cnt, 0);
    chk("r43_d_rdata", d_rdata, 0); chk("r43_i_rdata", i_rdata, 0);
    for (int k = 0; k < 8; k++) begin
      chk("r43_no_done", i_done, 0);
      step();
    end

    // Randomized traffic checked by the model
    run_random(3000);
    reset = 1; i_req = 0; d_req = 0; dma_br = 0;
    step();
    reset = 0;
    step();

    // Counter wrap on the narrow instance, MEM_LATENCY=2
    w_reset = 0;
    for (int g = 0; g < 256; g++) begin
      int k;
      w_d_req = 1;
      k = 0;
      while (!w_d_done && k < 20) begin step(); k++; end
      if (!w_d_done) begin
        chk("wrap_timeout", 1'b0, 1'b1);
        break;
      end
      if (g == 0) begin
        chk("w_lat_cycles", k, ML2 + 2);
        chk("w_d_rdata", w_d_rdata, 32'h1357_9BDF);
      end
      step();
      w_d_req = 0;
      step();
      if (g == 254) chk("w_cnt_ff", w_d_cnt, 8'hFF);
    end
    chk("w_cnt_wrap", w_d_cnt, 8'h00);
    chk("w_i_cnt", w_i_cnt, 8'h00);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
